ct_l2cache_dirty_ctrl: RTL and testbench
========================================

CT_L2CACHE_DIRTY_CTRL -- requirements
Module: ct_l2cache_dirty_ctrl

Interface
REQ-001 SHALL have parameter TAG_INDEX_WIDTH, default `L2C_TAG_INDEX_WIDTH; set index width (W below).
REQ-002 SHALL have one clock, forever_cpuclk (input, 1); all state on its rising edge.
REQ-003 SHALL have reset cpurst_b (input, 1); asynchronous, active-low.
REQ-004 SHALL have rd_req (in, 1), rd_idx (in, W), rd_rdy (out, 1); read request handshake.
REQ-005 SHALL have rd_vld (out, 1), rd_data (out, 144); read return.
REQ-006 SHALL have wr_req (in, 1), wr_idx (in, W), wr_way (in, 4), wr_field (in, 9), wr_rdy (out, 1); single-way field update.
REQ-007 SHALL have init_done (out, 1); array ready for traffic.
REQ-008 SHALL have dirty_cen, dirty_gwen (out, 1), dirty_idx (out, W), dirty_din, dirty_wen (out, 144); dirty_dout (in, 144); all SRAM-side pins active-low: CEN=0 access, GWEN=0 write, WEN bit=0 writes that bit.

Function
REQ-009 SHALL treat the 144-bit row as 16 way fields of 9 bits; way n occupies bits [9n+8:9n].
REQ-010 SHALL accept a read on rd_req&rd_rdy and a write on wr_req&wr_rdy; both may be accepted in the same cycle.
REQ-011 SHALL buffer accepted writes in a 2-entry in-order FIFO; wr_rdy = init_done & FIFO not full.
REQ-012 SHALL set rd_rdy = init_done & FIFO not full & no valid FIFO entry whose idx equals rd_idx (hazard).
REQ-013 SHALL arbitrate one SRAM access per cycle: FIFO full or hazard -> drain write; else accepted read -> read; else FIFO non-empty -> drain write; else idle.
REQ-014 SHALL drive SRAM pins from flops one cycle after arbitration; idle cycle drives cen=1, gwen=1, wen all 1s.
REQ-015 SHALL, for a drained write, drive gwen=0, dirty_din = wr_field replicated 16 times, dirty_wen = 0 only on bits of wr_way.
REQ-016 SHALL, for a read accepted in cycle 0, drive the SRAM in cycle 1, register dirty_dout, and present rd_vld=1 with rd_data in cycle 3 for exactly one cycle.
REQ-017 SHALL order a same-cycle read and write to the same idx read-first: the read returns pre-write data.
REQ-018 SHALL sustain one read per cycle back-to-back when FIFO is empty.

Reset
REQ-019 SHALL, on cpurst_b low, immediately clear FIFO, read pipeline and FSM; abandon in-flight reads with no rd_vld.
REQ-020 SHALL reset outputs: dirty_cen=1, dirty_gwen=1, dirty_wen=all 1s, dirty_idx=0, dirty_din=0, rd_vld=0, rd_data=0, rd_rdy=0, wr_rdy=0, init_done=0.

Configuration
REQ-021 SHALL support macro L2C_DIRTY_INIT_EN.
REQ-022 With L2C_DIRTY_INIT_EN: FSM INIT->IDLE; INIT writes idx 0..2^W-1, one per cycle, din=0, wen=all 0, gwen=0; after last index, IDLE and init_done=1 next cycle; reset during INIT restarts at idx 0.
REQ-023 Without L2C_DIRTY_INIT_EN: no sweep; init_done=1 from the first cycle after reset deassertion.

Structure
REQ-024 SHALL place way count (16), field width (9), row width (144) and FSM state encodings in shared package ct_l2cache_dirty_pkg.
REQ-025 SHALL implement the write FIFO as sub-module ct_l2cache_dirty_wbuf (2 entries, push/pop/full/empty, per-entry idx compare output).
REQ-026 SHALL connect the SRAM-side ports directly to the dirty array pins of the same names, with no glue logic.

Verification (W=9)
REQ-027 Reset release with macro on -> 512 consecutive write cycles idx 0..511, wen=all 0; init_done rises cycle 513; rd_rdy/wr_rdy 0 until then.
REQ-028 Write idx 0x12 way 5 field 0x1FF, then read 0x12 -> rd_data bits [53:45]=0x1FF, all other bits 0; rd_vld 3 cycles after read accepted.
REQ-029 Two writes to idx 0x20 and 0x21 with rd_req held -> wr_rdy drops when full; read stalls; writes drain before the read.
REQ-030 Read idx 0x30 while write to 0x30 is buffered -> rd_rdy=0 until write drains; read returns new field.
REQ-031 Same-cycle read and write to idx 0x40 (way 0, field 0x001) after init -> read returns 0; following read returns bit0=1.
REQ-032 cpurst_b asserted cycle after a read is accepted -> no rd_vld; SRAM pins return to idle values immediately; init restarts at idx 0.

Source files
------------

// File: rtl/ct_l2cache_dirty_pkg.sv
// Shared geometry, FSM encoding and write-command payload for the L2 dirty-array controller.
// Index width defaults to 9 when L2C_TAG_INDEX_WIDTH is not supplied by the build.
`ifndef L2C_TAG_INDEX_WIDTH
`define L2C_TAG_INDEX_WIDTH 9
`endif
package ct_l2cache_dirty_pkg;

  localparam int unsigned WAY_NUM    = 16;
  localparam int unsigned FIELD_W    = 9;
  localparam int unsigned ROW_W      = WAY_NUM * FIELD_W;
  localparam int unsigned WAY_W      = 4;
  localparam int unsigned WBUF_DEPTH = 2;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } dirty_state_e;

  typedef struct packed {
    logic [WAY_W-1:0]   way;
    logic [FIELD_W-1:0] data;
  } wr_cmd_t;

  // Active-high mask covering the field bits of one way within a row.
  function automatic logic [ROW_W-1:0] way_mask(input logic [WAY_W-1:0] way);
    logic [ROW_W-1:0] m;
    m = '0;
    for (int unsigned n = 0; n < WAY_NUM; n++) begin
      if (WAY_W'(n) == way) m[n*FIELD_W +: FIELD_W] = '1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ct_l2cache_dirty_wbuf.sv
// Two-entry in-order write buffer with a per-entry index compare for read hazard detection.
module ct_l2cache_dirty_wbuf
  import ct_l2cache_dirty_pkg::*;
#(
  parameter int unsigned IDX_W = 9
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  push_i,
  input  logic [IDX_W-1:0]      push_idx_i,
  input  wr_cmd_t               push_cmd_i,
  input  logic                  pop_i,
  input  logic [IDX_W-1:0]      cmp_idx_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [IDX_W-1:0]      head_idx_o,
  output wr_cmd_t               head_cmd_o,
  output logic [WBUF_DEPTH-1:0] match_c
);

  logic [WBUF_DEPTH-1:0] vld_q, vld_d;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [IDX_W-1:0]      idx_q [WBUF_DEPTH];
  wr_cmd_t               cmd_q [WBUF_DEPTH];

  always_comb begin
    vld_d = vld_q;
    if (pop_i)  vld_d[rd_ptr_q] = 1'b0;
    if (push_i) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge forever_cpuclk) begin
    if (push_i) begin
      idx_q[wr_ptr_q] <= push_idx_i;
      cmd_q[wr_ptr_q] <= push_cmd_i;
    end
  end

  always_comb begin
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      match_c[i] = vld_q[i] & (idx_q[i] == cmp_idx_i);
    end
  end

  assign full_o     = &vld_q;
  assign empty_o    = ~|vld_q;
  assign head_idx_o = idx_q[rd_ptr_q];
  assign head_cmd_o = cmd_q[rd_ptr_q];

endmodule

// File: rtl/ct_l2cache_dirty_ctrl.sv
// L2 dirty-array controller: one SRAM access per cycle, buffered way-field writes, 3-cycle reads.
// Define L2C_DIRTY_INIT_EN to zero every row after reset before traffic is accepted.
`ifndef L2C_TAG_INDEX_WIDTH
`define L2C_TAG_INDEX_WIDTH 9
`endif
module ct_l2cache_dirty_ctrl
  import ct_l2cache_dirty_pkg::*;
#(
  parameter int unsigned TAG_INDEX_WIDTH = `L2C_TAG_INDEX_WIDTH
) (
  input  logic                       forever_cpuclk,
  input  logic                       cpurst_b,
  input  logic                       rd_req,
  input  logic [TAG_INDEX_WIDTH-1:0] rd_idx,
  output logic                       rd_rdy,
  output logic                       rd_vld,
  output logic [ROW_W-1:0]           rd_data,
  input  logic                       wr_req,
  input  logic [TAG_INDEX_WIDTH-1:0] wr_idx,
  input  logic [WAY_W-1:0]           wr_way,
  input  logic [FIELD_W-1:0]         wr_field,
  output logic                       wr_rdy,
  output logic                       init_done,
  output logic                       dirty_cen,
  output logic                       dirty_gwen,
  output logic [TAG_INDEX_WIDTH-1:0] dirty_idx,
  output logic [ROW_W-1:0]           dirty_din,
  output logic [ROW_W-1:0]           dirty_wen,
  input  logic [ROW_W-1:0]           dirty_dout
);

  localparam int unsigned W = TAG_INDEX_WIDTH;
`ifdef L2C_DIRTY_INIT_EN
  localparam dirty_state_e RST_STATE = ST_INIT;
`else
  localparam dirty_state_e RST_STATE = ST_IDLE;
`endif

  dirty_state_e          state_q, state_d;
  logic                  init_done_q;
  logic                  cen_q, cen_d, gwen_q, gwen_d;
  logic [W-1:0]          idx_q, idx_d;
  logic [ROW_W-1:0]      din_q, din_d, wen_q, wen_d;
  logic                  rd_p1_q, rd_p2_q, rd_vld_q;
  logic [ROW_W-1:0]      rd_data_q;
  logic                  wb_full, wb_empty, wb_pop, hazard, rd_acc, wr_acc;
  logic [WBUF_DEPTH-1:0] wb_match;
  logic [W-1:0]          wb_head_idx;
  wr_cmd_t               wb_head_cmd, wr_cmd;
`ifdef L2C_DIRTY_INIT_EN
  logic [W-1:0]          sweep_q, sweep_d;
`endif

  assign wr_cmd = '{way: wr_way, data: wr_field};
  assign hazard = |wb_match;
  assign wr_rdy = init_done_q & ~wb_full;
  assign rd_rdy = wr_rdy & ~hazard;
  assign rd_acc = rd_req & rd_rdy;
  assign wr_acc = wr_req & wr_rdy;

  ct_l2cache_dirty_wbuf #(.IDX_W(W)) u_wbuf (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .push_i         (wr_acc),
    .push_idx_i     (wr_idx),
    .push_cmd_i     (wr_cmd),
    .pop_i          (wb_pop),
    .cmp_idx_i      (rd_idx),
    .full_o         (wb_full),
    .empty_o        (wb_empty),
    .head_idx_o     (wb_head_idx),
    .head_cmd_o     (wb_head_cmd),
    .match_c        (wb_match)
  );

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= RST_STATE;
      init_done_q <= 1'b0;
`ifdef L2C_DIRTY_INIT_EN
      sweep_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      init_done_q <= (state_q == ST_IDLE);
`ifdef L2C_DIRTY_INIT_EN
      sweep_q     <= sweep_d;
`endif
    end
  end

  // Arbitration: a read is only accepted when no write must drain first.
  always_comb begin
    state_d = state_q;
    cen_d   = 1'b1;
    gwen_d  = 1'b1;
    wen_d   = '1;
    idx_d   = idx_q;
    din_d   = din_q;
    wb_pop  = 1'b0;
`ifdef L2C_DIRTY_INIT_EN
    sweep_d = sweep_q;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef L2C_DIRTY_INIT_EN
        cen_d   = 1'b0;
        gwen_d  = 1'b0;
        wen_d   = '0;
        din_d   = '0;
        idx_d   = sweep_q;
        sweep_d = sweep_q + W'(1);
        if (&sweep_q) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        if (rd_acc) begin
          cen_d = 1'b0;
          idx_d = rd_idx;
        end else if (!wb_empty) begin
          wb_pop = 1'b1;
          cen_d  = 1'b0;
          gwen_d = 1'b0;
          idx_d  = wb_head_idx;
          din_d  = {WAY_NUM{wb_head_cmd.data}};
          wen_d  = ~way_mask(wb_head_cmd.way);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cen_q  <= 1'b1;
      gwen_q <= 1'b1;
      idx_q  <= '0;
      din_q  <= '0;
      wen_q  <= '1;
    end else begin
      cen_q  <= cen_d;
      gwen_q <= gwen_d;
      idx_q  <= idx_d;
      din_q  <= din_d;
      wen_q  <= wen_d;
    end
  end

  // Read return: SRAM access, SRAM output valid, registered return.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_p1_q   <= 1'b0;
      rd_p2_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_p1_q  <= rd_acc;
      rd_p2_q  <= rd_p1_q;
      rd_vld_q <= rd_p2_q;
      if (rd_p2_q) rd_data_q <= dirty_dout;
    end
  end

  assign init_done  = init_done_q;
  assign rd_vld     = rd_vld_q;
  assign rd_data    = rd_data_q;
  assign dirty_cen  = cen_q;
  assign dirty_gwen = gwen_q;
  assign dirty_idx  = idx_q;
  assign dirty_din  = din_q;
  assign dirty_wen  = wen_q;

endmodule

// File: tb/tb_ct_l2cache_dirty_ctrl.sv
// Directed bench for ct_l2cache_dirty_ctrl with a behavioural active-low dirty SRAM (W=9).
// Follows L2C_DIRTY_INIT_EN when the build defines it.
module tb_ct_l2cache_dirty_ctrl;

  localparam int unsigned W = 9;
`ifdef L2C_DIRTY_INIT_EN
  localparam logic [143:0] MEM_INIT = '1;
`else
  localparam logic [143:0] MEM_INIT = '0;
`endif

  logic           clk, cpurst_b;
  logic           rd_req, rd_rdy, rd_vld;
  logic [W-1:0]   rd_idx;
  logic [143:0]   rd_data;
  logic           wr_req, wr_rdy, init_done;
  logic [W-1:0]   wr_idx;
  logic [3:0]     wr_way;
  logic [8:0]     wr_field;
  logic           dirty_cen, dirty_gwen;
  logic [W-1:0]   dirty_idx;
  logic [143:0]   dirty_din, dirty_wen, dirty_dout;

  int total = 0;
  int bad   = 0;

  ct_l2cache_dirty_ctrl #(.TAG_INDEX_WIDTH(W)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (cpurst_b),
    .rd_req         (rd_req),
    .rd_idx         (rd_idx),
    .rd_rdy         (rd_rdy),
    .rd_vld         (rd_vld),
    .rd_data        (rd_data),
    .wr_req         (wr_req),
    .wr_idx         (wr_idx),
    .wr_way         (wr_way),
    .wr_field       (wr_field),
    .wr_rdy         (wr_rdy),
    .init_done      (init_done),
    .dirty_cen      (dirty_cen),
    .dirty_gwen     (dirty_gwen),
    .dirty_idx      (dirty_idx),
    .dirty_din      (dirty_din),
    .dirty_wen      (dirty_wen),
    .dirty_dout     (dirty_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous SRAM: per-bit active-low write enable, read data one edge after access.
  logic [143:0] mem [512];
  logic         model_ready = 1'b0;
  always @(posedge clk) begin
    if (!model_ready) begin
      for (int i = 0; i < 512; i++) mem[i] <= MEM_INIT;
      model_ready <= 1'b1;
    end else if (!dirty_cen) begin
      if (!dirty_gwen) mem[dirty_idx] <= (mem[dirty_idx] & dirty_wen) | (dirty_din & ~dirty_wen);
      else dirty_dout <= mem[dirty_idx];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Called on the negedge of the accepting cycle; reports latency, data, cycle-1 pins and the cycle after rd_vld.
  task automatic wait_rvld(input int max_cyc, output int lat, output logic [143:0] data,
                           output logic [10:0] pins1, output logic vld_next);
    lat = -1; data = '0; pins1 = '0;
    for (int c = 1; c <= max_cyc && lat < 0; c++) begin
      @(negedge clk);
      rd_req = 1'b0;
      wr_req = 1'b0;
      if (c == 1) pins1 = {dirty_cen, dirty_gwen, dirty_idx};
      if (rd_vld === 1'b1) begin
        lat  = c;
        data = rd_data;
      end
    end
    @(negedge clk);
    vld_next = rd_vld;
  endtask

  task automatic test_reset();
    cpurst_b = 1'b0; rd_req = 1'b0; rd_idx = '0; wr_req = 1'b0;
    wr_idx = '0; wr_way = '0; wr_field = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({dirty_cen, dirty_gwen, rd_vld, rd_rdy, wr_rdy, init_done} !== 6'b110000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 110000", {dirty_cen, dirty_gwen, rd_vld, rd_rdy, wr_rdy, init_done});
    end
    total++;
    if (dirty_wen !== {144{1'b1}} || dirty_idx !== '0 || dirty_din !== '0 || rd_data !== '0) begin
      bad++;
      $display("FAIL reset_data: got wen=%h idx=%h din=%h rd_data=%h want wen all ones, rest 0",
               dirty_wen, dirty_idx, dirty_din, rd_data);
    end
  endtask

  task automatic test_init();
    cpurst_b = 1'b1;
`ifdef L2C_DIRTY_INIT_EN
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      total++;
      if (dirty_cen !== 1'b0 || dirty_gwen !== 1'b0 || dirty_idx !== 9'(i) || dirty_wen !== '0 ||
          dirty_din !== '0 || init_done !== 1'b0 || rd_rdy !== 1'b0 || wr_rdy !== 1'b0) begin
        bad++;
        $display("FAIL init_sweep[%0d]: got cen=%b gwen=%b idx=%h done=%b rdy=%b%b want 0 0 %h 0 00",
                 i, dirty_cen, dirty_gwen, dirty_idx, init_done, rd_rdy, wr_rdy, 9'(i));
      end
    end
`endif
    @(negedge clk);
    total++;
    if ({init_done, rd_rdy, wr_rdy, dirty_cen, dirty_gwen} !== 5'b11111 || dirty_wen !== {144{1'b1}}) begin
      bad++;
      $display("FAIL init_done: got done/rdrdy/wrrdy/cen/gwen=%b want 11111",
               {init_done, rd_rdy, wr_rdy, dirty_cen, dirty_gwen});
    end
  endtask

  task automatic test_write_read();
    logic [143:0] e_din, e_wen, e_row, data;
    logic [10:0]  pins1;
    logic         vnext;
    int           lat;
    e_din = {16{9'h1FF}};
    e_wen = '1; e_wen[53:45] = '0;
    e_row = '0; e_row[53:45] = 9'h1FF;
    @(negedge clk);
    wr_req = 1'b1; wr_idx = 9'h012; wr_way = 4'd5; wr_field = 9'h1FF;
    #1;
    total++;
    if (wr_rdy !== 1'b1) begin bad++; $display("FAIL wr_accept: got wr_rdy=%b want 1", wr_rdy); end
    @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    total++;
    if (dirty_cen !== 1'b0 || dirty_gwen !== 1'b0 || dirty_idx !== 9'h012 || dirty_din !== e_din || dirty_wen !== e_wen) begin
      bad++;
      $display("FAIL wr_pins: got cen=%b gwen=%b idx=%h din=%h wen=%h want 0 0 012 %h %h",
               dirty_cen, dirty_gwen, dirty_idx, dirty_din, dirty_wen, e_din, e_wen);
    end
    rd_req = 1'b1; rd_idx = 9'h012;
    #1;
    total++;
    if (rd_rdy !== 1'b1) begin bad++; $display("FAIL rd_accept: got rd_rdy=%b want 1", rd_rdy); end
    wait_rvld(6, lat, data, pins1, vnext);
    total++;
    if (pins1 !== {1'b0, 1'b1, 9'h012}) begin bad++; $display("FAIL rd_pins: got %b want %b", pins1, {1'b0, 1'b1, 9'h012}); end
    total++;
    if (lat !== 3 || data !== e_row || vnext !== 1'b0) begin
      bad++;
      $display("FAIL rd_0x12: got lat=%0d data=%h vld_next=%b want 3 %h 0", lat, data, vnext, e_row);
    end
  endtask

  task automatic test_full_stall();
    logic [143:0] e_din, e_wen, e_row, data;
    logic [10:0]  pins1;
    logic         vnext;
    int           lat;
    @(negedge clk);
    rd_req = 1'b1; rd_idx = 9'h050;
    wr_req = 1'b1; wr_idx = 9'h020; wr_way = 4'd1; wr_field = 9'h0AA;
    #1;
    total++;
    if ({rd_rdy, wr_rdy} !== 2'b11) begin bad++; $display("FAIL full_c0_rdy: got %b want 11", {rd_rdy, wr_rdy}); end
    @(negedge clk);
    wr_idx = 9'h021; wr_way = 4'd2; wr_field = 9'h055;
    #1;
    total++;
    if ({rd_rdy, wr_rdy} !== 2'b11) begin bad++; $display("FAIL full_c1_rdy: got %b want 11", {rd_rdy, wr_rdy}); end
    @(negedge clk);
    total++;
    if ({rd_rdy, wr_rdy} !== 2'b00) begin bad++; $display("FAIL full_c2_rdy: got %b want 00", {rd_rdy, wr_rdy}); end
    total++;
    if ({dirty_cen, dirty_gwen, dirty_idx} !== {1'b0, 1'b1, 9'h050}) begin
      bad++; $display("FAIL full_c2_pins: got %b %b %h want 0 1 050", dirty_cen, dirty_gwen, dirty_idx);
    end
    wr_req = 1'b0; rd_idx = 9'h021;
    @(negedge clk);
    e_din = {16{9'h0AA}}; e_wen = '1; e_wen[17:9] = '0;
    total++;
    if (dirty_cen !== 1'b0 || dirty_gwen !== 1'b0 || dirty_idx !== 9'h020 || dirty_din !== e_din ||
        dirty_wen !== e_wen || rd_rdy !== 1'b0) begin
      bad++;
      $display("FAIL full_c3_drain: got cen=%b gwen=%b idx=%h wen=%h rd_rdy=%b want 0 0 020 %h 0",
               dirty_cen, dirty_gwen, dirty_idx, dirty_wen, rd_rdy, e_wen);
    end
    total++;
    if (rd_vld !== 1'b1 || rd_data !== '0) begin bad++; $display("FAIL full_c3_rvld: got %b %h want 1 0", rd_vld, rd_data); end
    @(negedge clk);
    e_wen = '1; e_wen[26:18] = '0;
    total++;
    if (dirty_gwen !== 1'b0 || dirty_idx !== 9'h021 || dirty_wen !== e_wen || rd_vld !== 1'b1 || rd_rdy !== 1'b1) begin
      bad++;
      $display("FAIL full_c4: got gwen=%b idx=%h wen=%h rd_vld=%b rd_rdy=%b want 0 021 %h 1 1",
               dirty_gwen, dirty_idx, dirty_wen, rd_vld, rd_rdy, e_wen);
    end
    e_row = '0; e_row[26:18] = 9'h055;
    wait_rvld(6, lat, data, pins1, vnext);
    total++;
    if (lat !== 3 || data !== e_row || pins1 !== {1'b0, 1'b1, 9'h021}) begin
      bad++;
      $display("FAIL full_read: got lat=%0d data=%h pins=%b want 3 %h %b", lat, data, pins1, e_row, {1'b0, 1'b1, 9'h021});
    end
  endtask

  task automatic test_hazard();
    logic [143:0] e_row, data;
    logic [10:0]  pins1;
    logic         vnext;
    int           lat;
    @(negedge clk);
    wr_req = 1'b1; wr_idx = 9'h030; wr_way = 4'd7; wr_field = 9'h123;
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b1; rd_idx = 9'h030;
    #1;
    total++;
    if (rd_rdy !== 1'b0) begin bad++; $display("FAIL hazard_block: got rd_rdy=%b want 0", rd_rdy); end
    @(negedge clk);
    total++;
    if (rd_rdy !== 1'b1 || dirty_gwen !== 1'b0 || dirty_idx !== 9'h030) begin
      bad++;
      $display("FAIL hazard_release: got rd_rdy=%b gwen=%b idx=%h want 1 0 030", rd_rdy, dirty_gwen, dirty_idx);
    end
    e_row = '0; e_row[71:63] = 9'h123;
    wait_rvld(6, lat, data, pins1, vnext);
    total++;
    if (lat !== 3 || data !== e_row) begin bad++; $display("FAIL hazard_read: got lat=%0d data=%h want 3 %h", lat, data, e_row); end
  endtask

  task automatic test_same_cycle();
    logic [143:0] e_row, data;
    logic [10:0]  pins1;
    logic         vnext;
    int           lat;
    @(negedge clk);
    rd_req = 1'b1; rd_idx = 9'h040;
    wr_req = 1'b1; wr_idx = 9'h040; wr_way = 4'd0; wr_field = 9'h001;
    #1;
    total++;
    if ({rd_rdy, wr_rdy} !== 2'b11) begin bad++; $display("FAIL same_rdy: got %b want 11", {rd_rdy, wr_rdy}); end
    wait_rvld(6, lat, data, pins1, vnext);
    total++;
    if (lat !== 3 || data !== '0) begin bad++; $display("FAIL same_first: got lat=%0d data=%h want 3 0", lat, data); end
    rd_req = 1'b1; rd_idx = 9'h040;
    e_row = '0; e_row[0] = 1'b1;
    wait_rvld(6, lat, data, pins1, vnext);
    total++;
    if (lat !== 3 || data !== e_row) begin bad++; $display("FAIL same_second: got lat=%0d data=%h want 3 %h", lat, data, e_row); end
  endtask

  task automatic test_back_to_back();
    logic [143:0] exp_row [4];
    logic [8:0]   ids [4];
    ids[0] = 9'h012; ids[1] = 9'h020; ids[2] = 9'h021; ids[3] = 9'h030;
    foreach (exp_row[k]) exp_row[k] = '0;
    exp_row[0][53:45] = 9'h1FF;
    exp_row[1][17:9]  = 9'h0AA;
    exp_row[2][26:18] = 9'h055;
    exp_row[3][71:63] = 9'h123;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (cyc >= 3 && cyc <= 6) begin
        total++;
        if (rd_vld !== 1'b1 || rd_data !== exp_row[cyc-3]) begin
          bad++;
          $display("FAIL b2b_data[%0d]: got vld=%b data=%h want 1 %h", cyc - 3, rd_vld, rd_data, exp_row[cyc-3]);
        end
      end
      if (cyc == 7) begin
        total++;
        if (rd_vld !== 1'b0) begin bad++; $display("FAIL b2b_tail: got rd_vld=%b want 0", rd_vld); end
      end
      if (cyc < 4) begin
        rd_req = 1'b1; rd_idx = ids[cyc];
        #1;
        total++;
        if (rd_rdy !== 1'b1) begin bad++; $display("FAIL b2b_rdy[%0d]: got %b want 1", cyc, rd_rdy); end
      end else begin
        rd_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midread();
    logic vld_seen;
    vld_seen = 1'b0;
    @(negedge clk);
    rd_req = 1'b1; rd_idx = 9'h012;
    #1;
    total++;
    if (rd_rdy !== 1'b1) begin bad++; $display("FAIL rst_rd_accept: got rd_rdy=%b want 1", rd_rdy); end
    @(negedge clk);
    rd_req = 1'b0;
    total++;
    if (dirty_cen !== 1'b0) begin bad++; $display("FAIL rst_rd_pins: got cen=%b want 0", dirty_cen); end
    cpurst_b = 1'b0;
    #1;
    total++;
    if ({dirty_cen, dirty_gwen, init_done, rd_rdy, wr_rdy} !== 5'b11000 || dirty_wen !== {144{1'b1}} || dirty_idx !== '0) begin
      bad++;
      $display("FAIL rst_async_pins: got cen/gwen/done/rdys=%b idx=%h want 11000 000",
               {dirty_cen, dirty_gwen, init_done, rd_rdy, wr_rdy}, dirty_idx);
    end
    repeat (2) begin
      @(negedge clk);
      vld_seen |= rd_vld;
    end
    cpurst_b = 1'b1;
`ifdef L2C_DIRTY_INIT_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vld_seen |= rd_vld;
      total++;
      if (dirty_cen !== 1'b0 || dirty_gwen !== 1'b0 || dirty_idx !== 9'(i)) begin
        bad++;
        $display("FAIL rst_sweep_restart[%0d]: got cen=%b gwen=%b idx=%h want 0 0 %h", i, dirty_cen, dirty_gwen, dirty_idx, 9'(i));
      end
    end
`else
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vld_seen |= rd_vld;
    end
    total++;
    if (init_done !== 1'b1 || dirty_cen !== 1'b1) begin
      bad++; $display("FAIL rst_reinit: got init_done=%b cen=%b want 1 1", init_done, dirty_cen);
    end
`endif
    total++;
    if (vld_seen !== 1'b0) begin bad++; $display("FAIL rst_no_rvld: got vld_seen=%b want 0", vld_seen); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_full_stall();
    test_hazard();
    test_same_cycle();
    test_back_to_back();
    test_reset_midread();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
